// File: rtl/example_text_fetch_unit.sv
// Instruction fetch initiator: owns the fetch PC, issues one-cycle-latency text bus reads,
// and buffers responses in a small prefetch FIFO that feeds the core over valid/ready.
package rv_config;
  localparam logic [31:0] TEXT_BEGIN = 32'h0040_0000;
  localparam logic [31:0] TEXT_END   = 32'h0FFF_FFFF;
endpackage

module example_text_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int          DEPTH      = 2,
  parameter logic [31:0] TEXT_BEGIN = rv_config::TEXT_BEGIN,
  parameter logic [31:0] TEXT_END   = rv_config::TEXT_END
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output logic [31:0] bus_address,
  input  logic [31:0] bus_read_data
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } entry_t;

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight_valid;
  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic          pop, push, issue, fault;
  logic [CW1-1:0] occ;
  entry_t        head, wr_entry;

  assign bus_address = fetch_pc;

  assign inst_valid = (count != '0);
  assign head       = mem[rd_ptr];
  assign inst_data  = inst_valid ? head.data  : 32'h0;
  assign inst_pc    = inst_valid ? head.pc    : 32'h0;
  assign inst_fault = inst_valid ? head.fault : 1'b0;

  assign pop  = inst_valid && inst_ready && !redirect_valid;
  assign push = inflight_valid && !redirect_valid;

  // A same-cycle pop frees a slot, which is what lets DEPTH=2 stream at full rate.
  assign occ   = {1'b0, count} + CW1'(inflight_valid) - CW1'(pop);
  assign issue = !redirect_valid && (occ < CW1'(DEPTH));

  // Out-of-range reads return garbage on the bus; zero the data so X never escapes.
  assign fault         = (inflight_pc < TEXT_BEGIN) || (inflight_pc > TEXT_END);
  assign wr_entry.pc    = inflight_pc;
  assign wr_entry.fault = fault;
  assign wr_entry.data  = fault ? 32'h0 : bus_read_data;

  always_ff @(posedge clock) begin
    if (!reset && push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc       <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= 32'h0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
    end else if (redirect_valid) begin
      fetch_pc       <= {redirect_pc[31:2], 2'b00};
      inflight_valid <= 1'b0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
    end else begin
      inflight_valid <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_example_text_fetch_unit.sv
// Bench for example_text_fetch_unit: directed vector table, hand-written corner sequences,
// and a queue scoreboard over a randomized ready/redirect run on a DEPTH=4 instance.
module tb_example_text_fetch_unit;
  localparam logic [31:0] TXT_B = 32'h0040_0000;
  localparam logic [31:0] TXT_E = 32'h0FFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_ready = 1'b0;

  logic        v2, f2, v4, f4;
  logic [31:0] d2, p2, a2, d4, p4, a4;
  logic [31:0] rd2 = 32'h0, rd4 = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  example_text_fetch_unit #(.DEPTH(2)) dut2 (
    .clock(clock), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_ready(inst_ready), .inst_valid(v2), .inst_data(d2), .inst_pc(p2), .inst_fault(f2),
    .bus_address(a2), .bus_read_data(rd2));

  example_text_fetch_unit #(.DEPTH(4)) dut4 (
    .clock(clock), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_ready(inst_ready), .inst_valid(v4), .inst_data(d4), .inst_pc(p4), .inst_fault(f4),
    .bus_address(a4), .bus_read_data(rd4));

  // Memory image; out-of-range reads return a poison word that must never reach the core.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a < TXT_B || a > TXT_E) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic is_fault(input logic [31:0] a);
    return (a < TXT_B) || (a > TXT_E);
  endfunction

  always @(posedge clock) begin
    rd2 <= memfn(a2);
    rd4 <= memfn(a4);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    checks++;
    if (32'(dut2.count) > 2 || 32'(dut4.count) > 4) begin
      errors++;
      $display("FAIL fifo_overflow actual=%0d/%0d expected<=2/4", dut2.count, dut4.count);
    end
  endtask

  task automatic chk2(input string name, input logic ev, input logic [31:0] epc,
                      input logic [31:0] ebus, input logic ef);
    logic [31:0] ed;
    ed = ev ? (ef ? 32'h0 : memfn(epc)) : 32'h0;
    chk({name, "_valid"}, 32'(v2), 32'(ev));
    chk({name, "_pc"},    p2, ev ? epc : 32'h0);
    chk({name, "_data"},  d2, ed);
    chk({name, "_fault"}, 32'(f2), 32'(ev ? ef : 1'b0));
    chk({name, "_bus"},   a2, ebus);
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; inst_ready = 1'b0; redirect_pc = 32'h0;
    step(); step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ebus;
    logic        ef;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  vec_t tbl [14];
  exp_t q [$];

  initial begin
    // Streaming from reset, redirect out of text range, then back in.
    tbl[0]  = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0040_0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0040_0004, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h0040_0000, 32'h0040_0008, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h0040_0004, 32'h0040_000C, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h0040_0008, 32'h0040_0010, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h0040_000C, 32'h0040_0014, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'h0040_0010, 32'h0040_0018, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0000_0000, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0000_0004, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h0000_0000, 32'h0000_0008, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 32'h0040_0000, 1'b1, 32'h0000_0004, 32'h0000_000C, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0040_0000, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0040_0004, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h0040_0000, 32'h0040_0008, 1'b0};

    do_reset();
    chk2("reset_state", 1'b0, 32'h0, 32'h0040_0000, 1'b0);
    for (int i = 0; i < 14; i++) begin
      chk2($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].ebus, tbl[i].ef);
      inst_ready = tbl[i].rdy;
      redirect_valid = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      step();
    end
    redirect_valid = 1'b0;

    // Held-off consumer: exactly DEPTH buffered, then a gap-free resume.
    do_reset();
    repeat (10) step();
    chk("stall_count2", 32'(dut2.count), 32'd2);
    chk2("stall_head", 1'b1, 32'h0040_0000, 32'h0040_0008, 1'b0);
    chk("stall_bus4", a4, 32'h0040_0010);
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk2($sformatf("resume%0d", i), 1'b1, 32'h0040_0000 + 32'(4 * i), 32'h0040_0008 + 32'(4 * i), 1'b0);
      step();
    end

    // Redirect with buffered entries and a read in flight, pop requested in the same cycle.
    do_reset();
    repeat (4) step();
    chk("full_count2", 32'(dut2.count), 32'd2);
    chk("inflight4", 32'(dut4.inflight_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0103; inst_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk2("redir_r1", 1'b0, 32'h0, 32'h0040_0100, 1'b0);
    chk("redir_r1_valid4", 32'(v4), 32'd0);
    chk("redir_r1_bus4", a4, 32'h0040_0100);
    step();
    chk2("redir_r2", 1'b0, 32'h0, 32'h0040_0104, 1'b0);
    step();
    chk2("redir_r3", 1'b1, 32'h0040_0100, 32'h0040_0108, 1'b0);
    chk("redir_r3_pc4", p4, 32'h0040_0100);

    // Reset while a head is valid, a read is outstanding and the core is popping.
    do_reset();
    inst_ready = 1'b1;
    step(); step();
    chk("pre_reset_valid", 32'(v2), 32'd1);
    chk("pre_reset_inflight", 32'(dut2.inflight_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk2("midreset", 1'b0, 32'h0, 32'h0040_0000, 1'b0);
    chk("midreset_valid4", 32'(v4), 32'd0);
    step(); step();
    chk2("restart", 1'b1, 32'h0040_0000, 32'h0040_0008, 1'b0);

    // Random ready stalls and redirects, scoreboarded on the DEPTH=4 instance.
    do_reset();
    for (int k = 0; k < 32; k++)
      q.push_back('{32'h0040_0000 + 32'(4 * k), memfn(32'h0040_0000 + 32'(4 * k)), 1'b0});
    begin
      int since;
      logic rdy, redir;
      logic [31:0] rpc, base;
      exp_t e;
      since = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        rdy = ($urandom_range(0, 3) != 0);
        redir = (since >= 20) || ($urandom_range(0, 24) == 0);
        case ($urandom_range(0, 7))
          0:       rpc = 32'h0000_0010 | 32'($urandom_range(0, 3));
          1:       rpc = TXT_E - 32'd7;
          default: rpc = TXT_B + (32'($urandom_range(0, 4095)) << 2) + 32'($urandom_range(0, 3));
        endcase
        if (v4 && rdy && !redir) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty actual_pc=%h expected=none", p4);
          end else begin
            e = q.pop_front();
            chk("sb_pc", p4, e.pc);
            chk("sb_data", d4, e.data);
            chk("sb_fault", 32'(f4), 32'(e.fault));
          end
        end
        if (redir) begin
          q.delete();
          base = {rpc[31:2], 2'b00};
          for (int k = 0; k < 32; k++) begin
            e.pc = base + 32'(4 * k);
            e.fault = is_fault(e.pc);
            e.data = e.fault ? 32'h0 : memfn(e.pc);
            q.push_back(e);
          end
          since = 0;
        end else begin
          since++;
        end
        inst_ready = rdy;
        redirect_valid = redir;
        redirect_pc = rpc;
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
